fc_loop_ctrl: RTL

//  Loop sequencer for one fully-connected layer pass: N_OUT neurons x N_IN inputs.

---
 rtl/fc_ctrl_pkg.sv | 15 +
 rtl/fc_modn_cnt.sv | 29 ++
 rtl/fc_loop_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/fc_ctrl_pkg.sv
// Shared types and default loop bounds for the
// fully-connected layer loop sequencer.
package fc_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WB   = 2'd2,
    DONE = 2'd3
  } fc_state_e;

  localparam int N_IN_DEF  = 110;
  localparam int N_OUT_DEF = 16;

endpackage

// File: rtl/fc_modn_cnt.sv
// Modulo-N index counter: wraps to zero by explicit
// compare against N-1, never by 2^W overflow.
module fc_modn_cnt #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  assign wrap = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fc_loop_ctrl.sv
// Loop sequencer for one fully-connected layer pass:
// N_OUT neurons x N_IN input beats, one writeback each.
module fc_loop_ctrl
  import fc_ctrl_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int N_OUT = N_OUT_DEF,
  localparam int IN_W  = $clog2(N_IN),
  localparam int OUT_W = $clog2(N_OUT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             mac_en,
  output logic             acc_clr,
  output logic [IN_W-1:0]  in_idx,
  output logic [OUT_W-1:0] out_idx,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic             busy,
  output logic             done
);

  fc_state_e state;
  fc_state_e state_n;

  logic in_wrap;
  logic out_wrap;
  logic out_inc;
  logic idx_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    wb_valid = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_n = RUN;
      end
      RUN: begin
        in_ready = 1'b1;
        if (in_valid && in_wrap) state_n = WB;
      end
      WB: begin
        wb_valid = 1'b1;
        if (wb_ready) state_n = out_wrap ? DONE : RUN;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
    endcase
    // abort outranks everything, including a pending done
    if (abort) begin
      state_n = IDLE;
      done    = 1'b0;
    end
  end

  assign mac_en  = in_ready & in_valid & ~abort;
  assign acc_clr = mac_en & (in_idx == '0);
  assign out_inc = wb_valid & wb_ready & ~abort;
  assign idx_clr = abort | ((state == IDLE) & start);
  assign busy    = (state != IDLE);

  fc_modn_cnt #(
    .N (N_IN),
    .W (IN_W)
  ) u_in_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (mac_en),
    .clr   (idx_clr),
    .cnt   (in_idx),
    .wrap  (in_wrap)
  );

  fc_modn_cnt #(
    .N (N_OUT),
    .W (OUT_W)
  ) u_out_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (out_inc),
    .clr   (idx_clr),
    .cnt   (out_idx),
    .wrap  (out_wrap)
  );

endmodule
